// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit running each access as byte transactions on a byte-wide RAM port.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses through misalign_o.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic        hold_i,
  input  logic        ram_grant_i,
  input  logic [7:0]  ram_din_i,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  output logic        ram_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o
`ifdef LSU_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  // Op codes mirror the pipeline's defines.v encoding
  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] EX_LB   = 8'h20;
  localparam logic [7:0] EX_LH   = 8'h21;
  localparam logic [7:0] EX_LW   = 8'h22;
  localparam logic [7:0] EX_LBU  = 8'h24;
  localparam logic [7:0] EX_LHU  = 8'h25;
  localparam logic [7:0] EX_SB   = 8'h28;
  localparam logic [7:0] EX_SH   = 8'h29;
  localparam logic [7:0] EX_SW   = 8'h2b;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  k, k_n, k_eff, nbytes;
  logic        is_load, is_store, sext, mem_op;
  logic        issuing, last_byte, store_done, load_done;
  logic        cap_valid;
  logic [1:0]  cap_slot;
  logic [31:0] asm_word, word, load_result, res_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    nbytes   = 3'd1;
    case (aluop_i)
      EX_LB:   begin is_load = 1'b1; sext = 1'b1; end
      EX_LBU:  is_load = 1'b1;
      EX_LH:   begin is_load = 1'b1; sext = 1'b1; nbytes = 3'd2; end
      EX_LHU:  begin is_load = 1'b1; nbytes = 3'd2; end
      EX_LW:   begin is_load = 1'b1; nbytes = 3'd4; end
      EX_SB:   is_store = 1'b1;
      EX_SH:   begin is_store = 1'b1; nbytes = 3'd2; end
      EX_SW:   begin is_store = 1'b1; nbytes = 3'd4; end
      MEM_NOP: ;
      default: ;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (nbytes == 3'd2 && mem_addr_i[0]) ||
                      (nbytes == 3'd4 && mem_addr_i[1:0] != 2'b00);
  assign misalign_o = (state == IDLE) && (is_load || is_store) && misaligned;
  assign mem_op     = (is_load || is_store) && !misaligned;
`else
  assign mem_op = is_load || is_store;
`endif

  // The first byte issues straight from IDLE so a granted SB never stalls
  assign issuing    = (state == IDLE && mem_op) || state == ISSUE;
  assign k_eff      = (state == ISSUE) ? k : 3'd0;
  assign last_byte  = (k_eff == nbytes - 3'd1);
  assign store_done = issuing && is_store && ram_grant_i && last_byte;
  assign load_done  = (state == DRAIN);

  // The final load byte is merged combinationally so the result is ready in the completion cycle
  always_comb begin
    word = asm_word;
    if (cap_valid) word[{cap_slot, 3'b000} +: 8] = ram_din_i;
    case (nbytes)
      3'd1:    load_result = sext ? {{24{word[7]}}, word[7:0]} : {24'd0, word[7:0]};
      3'd2:    load_result = sext ? {{16{word[15]}}, word[15:0]} : {16'd0, word[15:0]};
      default: load_result = word;
    endcase
  end

  always_comb begin
    state_n = state;
    k_n     = 3'd0;
    case (state)
      IDLE, ISSUE: begin
        if (issuing) begin
          state_n = ISSUE;
          if (ram_grant_i && last_byte)
            state_n = is_load ? DRAIN : (hold_i ? DONE : IDLE);
          else
            k_n = k_eff + {2'b00, ram_grant_i};
        end
      end
      DRAIN:   state_n = hold_i ? DONE : IDLE;
      DONE:    if (!hold_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_req_o   = issuing;
    ram_wr_o    = issuing && is_store;
    ram_addr_o  = issuing ? mem_addr_i + {29'd0, k_eff} : 32'd0;
    ram_dout_o  = (issuing && is_store) ? wdata_i[{k_eff[1:0], 3'b000} +: 8] : 8'd0;
    stall_req_o = issuing && !store_done;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    case (state)
      DONE: begin
        wd_o    = wd_q;
        wreg_o  = wreg_q;
        wdata_o = res_q;
      end
      DRAIN: begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = load_result;
      end
      default: begin
        if (!is_load && !is_store) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= 3'd0;
      cap_valid <= 1'b0;
      cap_slot  <= 2'd0;
      asm_word  <= 32'd0;
      res_q     <= 32'd0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cap_valid <= issuing && is_load && ram_grant_i;
      cap_slot  <= k_eff[1:0];
      if (cap_valid)
        asm_word[{cap_slot, 3'b000} +: 8] <= ram_din_i;
      else if (state == IDLE)
        asm_word <= 32'd0;
      if (load_done || store_done) begin
        res_q  <= is_load ? load_result : 32'd0;
        wd_q   <= is_load ? wd_i : 5'd0;
        wreg_q <= is_load && wreg_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a byte-wide RAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_lsu;

  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] EX_LB   = 8'h20;
  localparam logic [7:0] EX_LH   = 8'h21;
  localparam logic [7:0] EX_LW   = 8'h22;
  localparam logic [7:0] EX_LBU  = 8'h24;
  localparam logic [7:0] EX_SB   = 8'h28;
  localparam logic [7:0] EX_SH   = 8'h29;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic        hold_i;
  logic        ram_grant_i;
  logic [7:0]  ram_din_i;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_req_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
`ifdef LSU_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [7:0] wmem [0:1023];

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .hold_i(hold_i),
    .ram_grant_i(ram_grant_i), .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_req_o(ram_req_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
`ifdef LSU_ALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .stall_req_o(stall_req_o)
  );

  // Fixed read contents; anything else reads as zero
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h78;
      32'h101: return 8'h56;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      32'h104: return 8'hA0;
      32'h105: return 8'hB1;
      32'h200: return 8'h80;
      32'h210: return 8'h01;
      32'h211: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // RAM model: read data one cycle after a granted read, 0xEE otherwise
  always @(posedge clk) begin
    if (ram_req_o && ram_grant_i && !ram_wr_o) ram_din_i <= rom_byte(ram_addr_o);
    else ram_din_i <= 8'hEE;
    if (ram_req_o && ram_grant_i && ram_wr_o) begin
      wmem[ram_addr_o[9:0]] <= ram_dout_o;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wd, input logic wr);
    aluop_i = op; mem_addr_i = addr; wdata_i = data; wd_i = wd; wreg_i = wr;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    hold_i = 1'b0; ram_grant_i = 1'b1;
    tick; tick;
    @(negedge clk);
    checks++;
    if (stall_req_o !== 1'b0 || ram_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle: got stall=%b req=%b expected 0 0", stall_req_o, ram_req_o);
    end
    checks++;
    if (wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_wb: got wreg=%b wdata=%h expected 0 00000000", wreg_o, wdata_o);
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_passthrough;
    set_op(MEM_NOP, 32'h100, 32'hDEADBEEF, 5'd7, 1'b1);
    #1;
    checks++;
    if (wd_o !== 5'd7 || wreg_o !== 1'b1 || wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL pass_wb: got wd=%0d wreg=%b wdata=%h expected 7 1 deadbeef", wd_o, wreg_o, wdata_o);
    end
    checks++;
    if (ram_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL pass_noreq: got req=%b stall=%b expected 0 0", ram_req_o, stall_req_o);
    end
    tick;
  endtask

  task automatic test_lw;
    ram_grant_i = 1'b1; hold_i = 1'b0;
    set_op(EX_LW, 32'h100, 32'h0, 5'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (stall_req_o !== (c < 4)) begin
        errors++; $display("[TB] FAIL lw_stall c%0d: got %b expected %b", c, stall_req_o, (c < 4));
      end
      if (c < 4) begin
        checks++;
        if (ram_req_o !== 1'b1 || ram_wr_o !== 1'b0 || ram_addr_o !== 32'h100 + 32'(c)) begin
          errors++; $display("[TB] FAIL lw_issue c%0d: got req=%b wr=%b addr=%h expected 1 0 %h",
                             c, ram_req_o, ram_wr_o, ram_addr_o, 32'h100 + 32'(c));
        end
      end else begin
        checks++;
        if (wdata_o !== 32'h12345678 || wreg_o !== 1'b1 || wd_o !== 5'd3 || ram_req_o !== 1'b0) begin
          errors++; $display("[TB] FAIL lw_result: got wdata=%h wreg=%b wd=%0d req=%b expected 12345678 1 3 0",
                             wdata_o, wreg_o, wd_o, ram_req_o);
        end
      end
      tick;
    end
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_byte_half;
    logic [7:0]  ops   [3] = '{EX_LB, EX_LBU, EX_LH};
    logic [31:0] addrs [3] = '{32'h200, 32'h200, 32'h210};
    int          nb    [3] = '{1, 1, 2};
    logic [31:0] exp   [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    ram_grant_i = 1'b1; hold_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      set_op(ops[t], addrs[t], 32'h0, 5'd4, 1'b1);
      for (int c = 0; c <= nb[t]; c++) begin
        @(negedge clk);
        if (c < nb[t]) begin
          checks++;
          if (stall_req_o !== 1'b1 || ram_addr_o !== addrs[t] + 32'(c)) begin
            errors++; $display("[TB] FAIL bh_issue t%0d c%0d: got stall=%b addr=%h expected 1 %h",
                               t, c, stall_req_o, ram_addr_o, addrs[t] + 32'(c));
          end
        end else begin
          checks++;
          if (stall_req_o !== 1'b0 || wdata_o !== exp[t]) begin
            errors++; $display("[TB] FAIL bh_result t%0d: got stall=%b wdata=%h expected 0 %h",
                               t, stall_req_o, wdata_o, exp[t]);
          end
        end
        tick;
      end
    end
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_store_sh;
    logic        g     [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ea    [3] = '{32'h300, 32'h301, 32'h301};
    logic [7:0]  ed    [3] = '{8'hDD, 8'hCC, 8'hCC};
    logic        es    [3] = '{1'b1, 1'b1, 1'b0};
    int start_wr;
    start_wr = wr_count;
    hold_i = 1'b0;
    set_op(EX_SH, 32'h300, 32'hAABBCCDD, 5'd9, 1'b1);
    for (int c = 0; c < 3; c++) begin
      ram_grant_i = g[c];
      @(negedge clk);
      checks++;
      if (ram_req_o !== 1'b1 || ram_wr_o !== 1'b1 || ram_addr_o !== ea[c] || ram_dout_o !== ed[c]) begin
        errors++; $display("[TB] FAIL sh_issue c%0d: got req=%b wr=%b addr=%h dout=%h expected 1 1 %h %h",
                           c, ram_req_o, ram_wr_o, ram_addr_o, ram_dout_o, ea[c], ed[c]);
      end
      checks++;
      if (stall_req_o !== es[c] || wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
        errors++; $display("[TB] FAIL sh_stall c%0d: got stall=%b wreg=%b wdata=%h expected %b 0 00000000",
                           c, stall_req_o, wreg_o, wdata_o, es[c]);
      end
      tick;
    end
    ram_grant_i = 1'b1;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (wr_count - start_wr !== 2 || wmem[10'h300] !== 8'hDD || wmem[10'h301] !== 8'hCC) begin
      errors++; $display("[TB] FAIL sh_mem: got writes=%0d m300=%h m301=%h expected 2 dd cc",
                         wr_count - start_wr, wmem[10'h300], wmem[10'h301]);
    end
  endtask

  task automatic test_sb;
    ram_grant_i = 1'b1; hold_i = 1'b0;
    set_op(EX_SB, 32'h310, 32'h11223344, 5'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (stall_req_o !== 1'b0 || ram_req_o !== 1'b1 || ram_dout_o !== 8'h44 || ram_addr_o !== 32'h310) begin
      errors++; $display("[TB] FAIL sb_issue: got stall=%b req=%b dout=%h addr=%h expected 0 1 44 00000310",
                         stall_req_o, ram_req_o, ram_dout_o, ram_addr_o);
    end
    tick;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (wmem[10'h310] !== 8'h44) begin
      errors++; $display("[TB] FAIL sb_mem: got %h expected 44", wmem[10'h310]);
    end
  endtask

  task automatic test_hold;
    ram_grant_i = 1'b1; hold_i = 1'b1;
    set_op(EX_LW, 32'h100, 32'h0, 5'd5, 1'b1);
    for (int c = 0; c < 4; c++) tick;
    @(negedge clk);
    checks++;
    if (stall_req_o !== 1'b0 || wdata_o !== 32'h12345678) begin
      errors++; $display("[TB] FAIL hold_complete: got stall=%b wdata=%h expected 0 12345678", stall_req_o, wdata_o);
    end
    tick;
    for (int c = 5; c < 8; c++) begin
      if (c == 7) hold_i = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_req_o !== 1'b0 || stall_req_o !== 1'b0 || wdata_o !== 32'h12345678 ||
          wreg_o !== 1'b1 || wd_o !== 5'd5) begin
        errors++; $display("[TB] FAIL hold_done c%0d: got req=%b stall=%b wdata=%h wreg=%b wd=%0d expected 0 0 12345678 1 5",
                           c, ram_req_o, stall_req_o, wdata_o, wreg_o, wd_o);
      end
      tick;
    end
    set_op(MEM_NOP, 32'h0, 32'h00000055, 5'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (wdata_o !== 32'h00000055 || ram_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release: got wdata=%h req=%b stall=%b expected 00000055 0 0",
                         wdata_o, ram_req_o, stall_req_o);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    ram_grant_i = 1'b1; hold_i = 1'b0;
    set_op(EX_LW, 32'h100, 32'h0, 5'd6, 1'b1);
    tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (ram_req_o !== 1'b0 || ram_wr_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_dout_o !== 8'h0) begin
      errors++; $display("[TB] FAIL rstmid_ram: got req=%b wr=%b addr=%h dout=%h expected all 0",
                         ram_req_o, ram_wr_o, ram_addr_o, ram_dout_o);
    end
    checks++;
    if (stall_req_o !== 1'b0 || wreg_o !== 1'b0 || wd_o !== 5'd0 || wdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_wb: got stall=%b wreg=%b wd=%0d wdata=%h expected all 0",
                         stall_req_o, wreg_o, wd_o, wdata_o);
    end
    tick;
    // A fresh access after reset must start at byte 0 and assemble cleanly
    set_op(EX_LW, 32'h100, 32'h0, 5'd6, 1'b1);
    @(negedge clk);
    checks++;
    if (ram_addr_o !== 32'h100 || stall_req_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_restart: got addr=%h stall=%b expected 00000100 1", ram_addr_o, stall_req_o);
    end
    for (int c = 0; c < 4; c++) tick;
    @(negedge clk);
    checks++;
    if (wdata_o !== 32'h12345678 || stall_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_result: got wdata=%h stall=%b expected 12345678 0", wdata_o, stall_req_o);
    end
    tick;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_misaligned;
    ram_grant_i = 1'b1; hold_i = 1'b0;
    set_op(EX_LW, 32'h102, 32'h0, 5'd8, 1'b1);
`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    checks++;
    if (misalign_o !== 1'b1 || ram_req_o !== 1'b0 || wreg_o !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL misalign_flag: got mis=%b req=%b wreg=%b stall=%b expected 1 0 0 0",
                         misalign_o, ram_req_o, wreg_o, stall_req_o);
    end
    tick;
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h102 + 32'(c)) begin
          errors++; $display("[TB] FAIL misalign_issue c%0d: got req=%b addr=%h expected 1 %h",
                             c, ram_req_o, ram_addr_o, 32'h102 + 32'(c));
        end
      end else begin
        checks++;
        if (wdata_o !== 32'hB1A01234 || stall_req_o !== 1'b0) begin
          errors++; $display("[TB] FAIL misalign_result: got wdata=%h stall=%b expected b1a01234 0", wdata_o, stall_req_o);
        end
      end
      tick;
    end
`endif
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    hold_i = 1'b0;
    ram_grant_i = 1'b0;
    set_op(MEM_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    test_reset;
    test_passthrough;
    test_lw;
    test_byte_half;
    test_store_sh;
    test_sb;
    test_hold;
    test_reset_mid;
    test_misaligned;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
